audio_i2s_tx: RTL and testbench
===============================

Name: audio_i2s_tx

Overview:
- I2S master transmitter for the audio path: consumes stereo PCM frames from the FT2232 receive datapath through a valid/ready handshake.
- Serialises frames to an external DAC as BCLK, LRCK and SDATA, all derived from the 24.576 MHz audio clock.
- Default divider gives 64 BCLK per frame, 3.072 MHz BCLK and 48 kHz LRCK.
- Contains a one-frame holding buffer plus the active frame register, and reports underruns.

Parameters:
- BCLK_DIV, 8: clk_i cycles per BCLK period. Must be even and ≥4.
- SAMPLE_BITS, 24: PCM bits per channel, ≤32. Sent MSB first in a 32-bit slot; remaining slot bits are 0.
- UNDERRUN_W, 16: width of the saturating underrun counter.

Ports:
- clk_i  in  1  audio clock (24.576 MHz)
- reset_i  in  1  synchronous, active-high reset
- enable_i  in  1  1 = run the serial interface; 0 = idle
- sample_left_i  in  SAMPLE_BITS  left PCM sample, two's complement
- sample_right_i  in  SAMPLE_BITS  right PCM sample
- sample_valid_i  in  1  frame present on the sample inputs
- sample_ready_o  out  1  holding buffer empty; a frame is accepted when valid and ready are both 1
- i2s_bclk_o  out  1  bit clock
- i2s_lrck_o  out  1  word select (0 = left, 1 = right)
- i2s_sdata_o  out  1  serial data
- frame_start_o  out  1  one-cycle pulse at each frame load
- underrun_o  out  1  one-cycle pulse when a frame load finds the holding buffer empty
- underrun_count_o  out  UNDERRUN_W  saturating count of underruns

Behaviour:
- Reset (reset_i=1 on a clk_i edge): all counters 0, holding buffer empty, frame register 0. Outputs i2s_bclk_o, i2s_lrck_o, i2s_sdata_o, frame_start_o, underrun_o = 0; underrun_count_o = 0.
- sample_ready_o = ~buf_full & ~reset_i. It reads 0 during reset and 1 on the first cycle after reset.
- Counters:
  - div_cnt counts 0..BCLK_DIV-1.
  - bit_cnt counts 0..63 and advances when div_cnt wraps to 0.
  - While enable_i=0, both counters are held at 0 and the serial outputs are driven 0.
- Frame-load event: a cycle with enable_i=1, div_cnt=0 and bit_cnt=0. This is also the first enabled cycle after enable_i rises.
  - If the buffer is full: frame register ← buffer, buffer cleared, frame_start_o=1 on the next cycle.
  - If the buffer is empty: frame register ← 0, frame_start_o=1 and underrun_o=1 on the next cycle; underrun_count_o increments and saturates at all-ones.
- Accept: when sample_valid_i & sample_ready_o, the buffer captures {left, right} and becomes full on the next cycle.
  - Accept and load can occur in the same cycle only when the buffer was empty. That counts as an underrun; the newly accepted frame waits for the next load.
- Serial outputs: combinational from (div_cnt, bit_cnt), then registered, so 1 clk_i latency.
  - bclk = (div_cnt ≥ BCLK_DIV/2). Data and LRCK change only on BCLK falling edges (div_cnt=0).
  - lrck = bit_cnt[5].
  - I2S one-bit delay: let k = (bit_cnt−1) mod 64, ch = k[5], p = k[4:0].
  - sdata = frame[ch][SAMPLE_BITS−1−p] when p < SAMPLE_BITS, else 0.
  - At bit_cnt=0 the data bit is the final padding bit of the previous right slot, 0.
- enable_i falling mid-frame: counters and outputs go to 0 on the next cycle; the current frame is abandoned; the buffer contents are kept.
- reset_i mid-frame: reset wins over every other event in that cycle, including a pending accept.
- One frame per 64·BCLK_DIV clk_i cycles (512 at default).

Test Plan:
1. Reset released, enable_i=1, no samples → frame_start_o and underrun_o pulse every 512 cycles; sdata constant 0; underrun_count_o = 1, 2, 3…; sample_ready_o=1.
2. Preload L=24'hA50F01, R=24'h800001 with enable_i=0, then enable → bclk period 8 clk, high for 4 clk. LRCK low 32 BCLKs then high 32. Left slot bits 1..24 = A50F01 MSB first, then 8 zeros. Right MSB appears one BCLK after LRCK rises. No underrun.
3. Continuous valid (source always ready) → exactly one accept per 512 cycles; sample_ready_o is low between an accept and the next load; underrun_count_o stays 0.
4. Set UNDERRUN_W=2 and starve for 5 frames → underrun_count_o = 1, 2, 3, 3, 3.
5. Assert reset_i at bit_cnt=40 with the buffer full → all outputs 0 on the next cycle; after release sample_ready_o=1, and the first enabled frame load is an underrun.
6. Deassert enable_i mid-left slot, re-enable 100 cycles later → outputs 0 while disabled. The new frame restarts at bit_cnt=0 and loads the buffered frame retained across the disable.

Source files
------------

// File: rtl/audio_i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module   : audio_i2s_tx
//  Purpose  : I2S master transmitter. Accepts stereo PCM frames through a
//             valid/ready handshake into a one-frame holding buffer, and
//             serialises the active frame as BCLK / LRCK / SDATA with the
//             standard one-bit I2S data delay in 32-bit slots.
//  Revision : 1.0  initial release
// ============================================================================
module audio_i2s_tx #(
  parameter int BCLK_DIV    = 8,   // clk_i cycles per BCLK period, even, >= 4
  parameter int SAMPLE_BITS = 24,  // PCM bits per channel, <= 32
  parameter int UNDERRUN_W  = 16   // width of the saturating underrun counter
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   enable_i,
  input  logic [SAMPLE_BITS-1:0] sample_left_i,
  input  logic [SAMPLE_BITS-1:0] sample_right_i,
  input  logic                   sample_valid_i,
  output logic                   sample_ready_o,
  output logic                   i2s_bclk_o,
  output logic                   i2s_lrck_o,
  output logic                   i2s_sdata_o,
  output logic                   frame_start_o,
  output logic                   underrun_o,
  output logic [UNDERRUN_W-1:0]  underrun_count_o
);

  // Divider counter geometry. BCLK_DIV >= 4 guarantees at least two bits.
  localparam int                 c_div_w    = $clog2(BCLK_DIV);
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(BCLK_DIV - 1);
  localparam logic [c_div_w-1:0] c_div_half = c_div_w'(BCLK_DIV / 2);
  localparam logic [c_div_w-1:0] c_div_one  = c_div_w'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_div_w-1:0]     r_div_cnt;
  logic [5:0]             r_bit_cnt;

  logic                   r_buf_full;
  logic [SAMPLE_BITS-1:0] r_buf_left;
  logic [SAMPLE_BITS-1:0] r_buf_right;

  logic [SAMPLE_BITS-1:0] r_frame_left;
  logic [SAMPLE_BITS-1:0] r_frame_right;

  logic                   r_bclk;
  logic                   r_lrck;
  logic                   r_sdata;
  logic                   r_frame_start;
  logic                   r_underrun;
  logic [UNDERRUN_W-1:0]  r_underrun_count;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic                   w_ready;
  logic                   w_accept;
  logic                   w_div_wrap;
  logic                   w_load;

  logic [5:0]             w_k;       // bit_cnt - 1, wraps 0 -> 63
  logic                   w_ch;      // 0 = left slot, 1 = right slot
  logic [4:0]             w_p;       // bit position inside the 32-bit slot
  logic [SAMPLE_BITS-1:0] w_word;
  logic [31:0]            w_slot;    // sample left-justified in a 32-bit slot
  logic                   w_bclk;
  logic                   w_lrck;
  logic                   w_sdata;

  // Ready drops during reset so an upstream source never sees a handshake
  // that the reset is about to discard.
  assign w_ready    = ~r_buf_full & ~reset_i;
  assign w_accept   = sample_valid_i & w_ready;
  assign w_div_wrap = (r_div_cnt == c_div_last);

  // Frame boundary: the first enabled cycle of every 64-bit frame. Because
  // counters are held at 0 while disabled, the first cycle after enable_i
  // rises is always a load.
  assign w_load = enable_i & (r_div_cnt == '0) & (r_bit_cnt == 6'd0);

  // One-bit I2S delay: data for slot bit p appears during bit_cnt = p + 1.
  assign w_k    = r_bit_cnt - 6'd1;
  assign w_ch   = w_k[5];
  assign w_p    = w_k[4:0];
  assign w_word = w_ch ? r_frame_right : r_frame_left;

  // Place the sample MSB-first in the slot with zero padding below it.
  if (SAMPLE_BITS == 32) begin : g_slot_full
    assign w_slot = w_word;
  end else begin : g_slot_pad
    assign w_slot = {w_word, {(32 - SAMPLE_BITS){1'b0}}};
  end

  // ~w_p == 31 - w_p for a 5-bit index, i.e. MSB of the slot first.
  // bit_cnt = 0 carries the last padding bit of the previous right slot,
  // which is forced to 0 so a full 32-bit sample cannot leak the new frame.
  assign w_sdata = (r_bit_cnt != 6'd0) & w_slot[~w_p];
  assign w_bclk  = (r_div_cnt >= c_div_half);
  assign w_lrck  = r_bit_cnt[5];

  // --------------------------------------------------------------------------
  // Sequential logic
  // --------------------------------------------------------------------------

  // BCLK divider and bit counter; both parked at 0 while disabled.
  always_ff @(posedge clk_i) begin
    if (reset_i || !enable_i) begin
      r_div_cnt <= '0;
      r_bit_cnt <= 6'd0;
    end else if (w_div_wrap) begin
      r_div_cnt <= '0;
      r_bit_cnt <= r_bit_cnt + 6'd1;
    end else begin
      r_div_cnt <= r_div_cnt + c_div_one;
    end
  end

  // Holding buffer: filled by an accept, emptied by a frame load. An accept
  // can only happen while empty, so it never collides with a load that
  // drains a full buffer; an accept coinciding with an empty-buffer load
  // keeps its frame for the following load.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_buf_full  <= 1'b0;
      r_buf_left  <= '0;
      r_buf_right <= '0;
    end else if (w_accept) begin
      r_buf_full  <= 1'b1;
      r_buf_left  <= sample_left_i;
      r_buf_right <= sample_right_i;
    end else if (w_load) begin
      r_buf_full  <= 1'b0;
    end
  end

  // Active frame register: takes the buffered frame at each load, or
  // silence if the buffer ran dry.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_frame_left  <= '0;
      r_frame_right <= '0;
    end else if (w_load) begin
      r_frame_left  <= r_buf_full ? r_buf_left  : '0;
      r_frame_right <= r_buf_full ? r_buf_right : '0;
    end
  end

  // Frame-start / underrun pulses and the saturating underrun counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_frame_start    <= 1'b0;
      r_underrun       <= 1'b0;
      r_underrun_count <= '0;
    end else begin
      r_frame_start <= w_load;
      r_underrun    <= w_load & ~r_buf_full;
      if (w_load && !r_buf_full && !(&r_underrun_count)) begin
        r_underrun_count <= r_underrun_count + 1'b1;
      end
    end
  end

  // Registered serial outputs, forced low while disabled.
  always_ff @(posedge clk_i) begin
    if (reset_i || !enable_i) begin
      r_bclk  <= 1'b0;
      r_lrck  <= 1'b0;
      r_sdata <= 1'b0;
    end else begin
      r_bclk  <= w_bclk;
      r_lrck  <= w_lrck;
      r_sdata <= w_sdata;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign sample_ready_o   = w_ready;
  assign i2s_bclk_o       = r_bclk;
  assign i2s_lrck_o       = r_lrck;
  assign i2s_sdata_o      = r_sdata;
  assign frame_start_o    = r_frame_start;
  assign underrun_o       = r_underrun;
  assign underrun_count_o = r_underrun_count;

endmodule
`default_nettype wire

// File: tb/tb_audio_i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_audio_i2s_tx
//  Purpose  : Directed self-checking bench for audio_i2s_tx (default
//             parameters), plus a second instance with a 2-bit underrun
//             counter to exercise saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_audio_i2s_tx;

  logic        clk = 1'b0;
  logic        r_reset;
  logic        r_enable;
  logic [23:0] r_left;
  logic [23:0] r_right;
  logic        r_valid;

  logic        w_ready, w_bclk, w_lrck, w_sdata, w_fs, w_ur;
  logic [15:0] w_ucnt;

  logic        w2_ready, w2_bclk, w2_lrck, w2_sdata, w2_fs, w2_ur;
  logic [1:0]  w2_ucnt;
  logic        r_valid2 = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  // 10 ns clock period
  always #5 clk = ~clk;

  audio_i2s_tx #(.BCLK_DIV(8), .SAMPLE_BITS(24), .UNDERRUN_W(16)) dut (
    .clk_i(clk), .reset_i(r_reset), .enable_i(r_enable),
    .sample_left_i(r_left), .sample_right_i(r_right),
    .sample_valid_i(r_valid), .sample_ready_o(w_ready),
    .i2s_bclk_o(w_bclk), .i2s_lrck_o(w_lrck), .i2s_sdata_o(w_sdata),
    .frame_start_o(w_fs), .underrun_o(w_ur), .underrun_count_o(w_ucnt)
  );

  // Always-starved instance sharing reset/enable with the main one.
  audio_i2s_tx #(.BCLK_DIV(8), .SAMPLE_BITS(24), .UNDERRUN_W(2)) dut_sat (
    .clk_i(clk), .reset_i(r_reset), .enable_i(r_enable),
    .sample_left_i(r_left), .sample_right_i(r_right),
    .sample_valid_i(r_valid2), .sample_ready_o(w2_ready),
    .i2s_bclk_o(w2_bclk), .i2s_lrck_o(w2_lrck), .i2s_sdata_o(w2_sdata),
    .frame_start_o(w2_fs), .underrun_o(w2_ur), .underrun_count_o(w2_ucnt)
  );

  // Count one comparison and report it if it does not match.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; sample point is 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at the sample right after a load that took a buffered frame.
  // Checks {bclk, lrck, sdata, frame_start, underrun} over the 512 cycles of
  // the frame against a hand-built 64-bit serial stream:
  // 1 delay bit, 24 left bits, 8 pad, 24 right bits, 7 pad.
  task automatic check_frame(input string tag, input logic [23:0] l, input logic [23:0] r);
    logic [63:0] s;
    logic [4:0]  e;
    int          b;
    s = {1'b0, l, 8'h00, r, 7'h00};
    for (int j = 0; j < 512; j++) begin
      b = j / 8;
      e = {((j % 8) >= 4), (b >= 32), s[63 - b], (j == 0), 1'b0};
      check(tag, {27'd0, w_bclk, w_lrck, w_sdata, w_fs, w_ur}, {27'd0, e});
      if (j == 511) check({tag, "_ucnt"}, 32'(w_ucnt), 32'd0);
      step();
    end
  endtask

  initial begin
    int  cnt;
    int  rdy_ones;
    int  fs_n;
    int  ur_n;
    logic sd_seen;

    r_reset  = 1'b1;
    r_enable = 1'b1;
    r_valid  = 1'b0;
    r_left   = '0;
    r_right  = '0;
    repeat (3) step();

    // ---------------- reset state ----------------
    check("rst_outs", {27'd0, w_bclk, w_lrck, w_sdata, w_fs, w_ur}, 32'd0);
    check("rst_ready", 32'(w_ready), 32'd0);
    check("rst_ucnt", 32'(w_ucnt), 32'd0);

    // ---------------- starved: underrun every frame, saturation ----------
    r_reset = 1'b0;
    step();
    check("t1_first_load", {30'd0, w_fs, w_ur}, 32'd3);
    check("t1_ready", 32'(w_ready), 32'd1);
    check("t1_ucnt", 32'(w_ucnt), 32'd1);
    check("t4_ucnt2", 32'(w2_ucnt), 32'd1);
    sd_seen = 1'b0;
    for (int n = 2; n <= 5; n++) begin
      cnt = 0;
      do begin
        step();
        cnt++;
        if (w_sdata) sd_seen = 1'b1;
      end while (!w_fs && cnt < 600);
      check("t1_period", cnt, 512);
      check("t1_underrun", 32'(w_ur), 32'd1);
      check("t1_ucnt", 32'(w_ucnt), n);
      check("t4_ucnt2", 32'(w2_ucnt), (n > 3) ? 3 : n);
      check("t1_ready", 32'(w_ready), 32'd1);
    end
    check("t1_sdata_zero", 32'(sd_seen), 32'd0);

    // ---------------- preloaded frame, full waveform ----------------
    r_reset  = 1'b1;
    r_enable = 1'b0;
    repeat (2) step();
    r_reset = 1'b0;
    step();
    check("t2_ready_after_rst", 32'(w_ready), 32'd1);
    r_left  = 24'hA50F01;
    r_right = 24'h800001;
    r_valid = 1'b1;
    step();
    r_valid = 1'b0;
    check("t2_ready_full", 32'(w_ready), 32'd0);
    check("t2_idle_outs", {27'd0, w_bclk, w_lrck, w_sdata, w_fs, w_ur}, 32'd0);
    r_enable = 1'b1;
    step();
    check_frame("t2_frame", 24'hA50F01, 24'h800001);

    // ---------------- continuous source ----------------
    r_reset  = 1'b1;
    r_enable = 1'b0;
    r_valid  = 1'b1;
    r_left   = 24'h123456;
    r_right  = 24'h654321;
    repeat (2) step();
    r_reset = 1'b0;
    step();                       // buffer filled while disabled
    r_enable = 1'b1;
    step();                       // first load, no underrun
    rdy_ones = 0;
    fs_n     = 0;
    ur_n     = 0;
    for (int i = 0; i < 1536; i++) begin
      if (w_ready) rdy_ones++;
      if (w_fs) fs_n++;
      if (w_ur) ur_n++;
      step();
    end
    check("t3_ready_cycles", rdy_ones, 3);
    check("t3_frame_starts", fs_n, 3);
    check("t3_underruns", ur_n, 0);
    check("t3_ucnt", 32'(w_ucnt), 32'd0);
    check("t3_load", {30'd0, w_fs, w_ur}, 32'd2);

    // ---------------- reset mid-frame (bit_cnt = 40) ----------------
    repeat (319) step();          // counters now at div 0, bit 40
    check("t5_buf_full", 32'(w_ready), 32'd0);
    check("t5_pre_lrck", 32'(w_lrck), 32'd1);
    r_reset = 1'b1;               // valid still high: reset must win
    step();
    check("t5_rst_outs", {27'd0, w_bclk, w_lrck, w_sdata, w_fs, w_ur}, 32'd0);
    check("t5_rst_ready", 32'(w_ready), 32'd0);
    check("t5_rst_ucnt", 32'(w_ucnt), 32'd0);
    r_reset = 1'b0;
    r_valid = 1'b0;
    step();
    check("t5_ready", 32'(w_ready), 32'd1);
    check("t5_load_underrun", {30'd0, w_fs, w_ur}, 32'd3);
    check("t5_ucnt", 32'(w_ucnt), 32'd1);

    // ---------------- disable mid-frame, buffer retained ----------------
    r_reset  = 1'b1;
    r_enable = 1'b0;
    repeat (2) step();
    r_reset = 1'b0;
    step();
    r_left  = 24'hA50F01;
    r_right = 24'h800001;
    r_valid = 1'b1;
    step();
    r_valid  = 1'b0;
    r_enable = 1'b1;
    step();                       // load frame A
    check("t6_loadA", {30'd0, w_fs, w_ur}, 32'd2);
    r_left  = 24'h13579B;
    r_right = 24'hFEDCBA;
    r_valid = 1'b1;
    step();                       // buffer frame B
    r_valid = 1'b0;
    repeat (98) step();           // mid-left slot
    r_enable = 1'b0;
    sd_seen  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (w_bclk | w_lrck | w_sdata | w_fs | w_ur) sd_seen = 1'b1;
    end
    check("t6_disabled_zero", 32'(sd_seen), 32'd0);
    check("t6_buf_kept", 32'(w_ready), 32'd0);
    r_enable = 1'b1;
    step();
    check("t6_ready_after_load", 32'(w_ready), 32'd1);
    check_frame("t6_frameB", 24'h13579B, 24'hFEDCBA);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
